emb_block_core: RTL and testbench



---
 rtl/emb_block_core_pkg.sv | 31 +++
 rtl/emb_block_core_if.sv | 25 ++
 rtl/emb_block_core_emb_rom.sv | 12 +
 rtl/emb_block_core.sv | 82 ++++++++
 tb/tb_emb_block_core.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/emb_block_core_pkg.sv
// Shared constants and types for the character-embedding front end.
// The width macros may be overridden before this file is compiled.
`ifndef CHAR_LEN
`define CHAR_LEN 8
`endif
`ifndef EMB_DIM
`define EMB_DIM 24
`endif
`ifndef N_LEN
`define N_LEN 16
`endif

package emb_block_core_pkg;

    localparam int CHAR_LEN = `CHAR_LEN;
    localparam int EMB_DIM  = `EMB_DIM;
    localparam int N_LEN    = `N_LEN;
    localparam int Q_W      = EMB_DIM * N_LEN;
    localparam int IDX_W    = 5;

    localparam logic [CHAR_LEN-1:0] EMB_MASK = CHAR_LEN'(8'hA5);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(N_LEN);

    typedef logic [CHAR_LEN-1:0] char_t;
    typedef logic [EMB_DIM-1:0]  emb_t;
    typedef logic [Q_W-1:0]      seq_t;
    typedef logic [IDX_W-1:0]    idx_t;

endpackage

// File: rtl/emb_block_core_if.sv
// Character stream in, packed embedding sequence out.
interface emb_block_core_if
    import emb_block_core_pkg::*;
();

    logic  run;
    char_t d;
    logic  valid;
    seq_t  q;

    modport master (
        output run,
        output d,
        input  valid,
        input  q
    );

    modport slave (
        input  run,
        input  d,
        output valid,
        output q
    );

endinterface

// File: rtl/emb_block_core_emb_rom.sv
// Fixed embedding table: emb(c) = {c, ~c, c ^ A5}.
// Kept standalone so a trained table can drop in later.
module emb_rom
    import emb_block_core_pkg::*;
(
    input  char_t c,
    output emb_t  e
);

    assign e = {c, ~c, c ^ EMB_MASK};

endmodule

// File: rtl/emb_block_core.sv
// Packs N_LEN consecutive character embeddings into one word.
// Slot 0 holds the first character of the sequence.
module emb_block_core
    import emb_block_core_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    emb_block_core_if.slave bus
);

    idx_t             idx;
    idx_t             idx_n;
    logic             valid_r;
    logic             valid_n;
    seq_t             q_r;
    logic [N_LEN-1:0] we;
    logic             fill;
    emb_t             emb;

    emb_rom u_rom (
        .c (bus.d),
        .e (emb)
    );

    assign fill = bus.run && (idx < IDX_FULL);

    // Idle resets the sequence; a full sequence holds until run drops.
    always_comb begin
        idx_n   = idx;
        valid_n = valid_r;
        unique case (1'b1)
            !bus.run: begin
                idx_n   = '0;
                valid_n = 1'b0;
            end
            fill: begin
                idx_n = idx + idx_t'(1);
                if (idx == IDX_LAST) begin
                    valid_n = 1'b1;
                end
            end
            default: begin
                idx_n   = idx;
                valid_n = valid_r;
            end
        endcase
    end

    always_comb begin
        we = '0;
        for (int k = 0; k < N_LEN; k++) begin
            we[k] = fill && (idx == idx_t'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            valid_r <= 1'b0;
        end else begin
            idx     <= idx_n;
            valid_r <= valid_n;
        end
    end

    // q is deliberately not cleared when run drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= '0;
        end else begin
            for (int k = 0; k < N_LEN; k++) begin
                if (we[k]) begin
                    q_r[k*EMB_DIM +: EMB_DIM] <= emb;
                end
            end
        end
    end

    assign bus.valid = valid_r;
    assign bus.q     = q_r;

endmodule

// File: tb/tb_emb_block_core.sv
// Directed bench for the embedding front end.
module tb_emb_block_core;
    import emb_block_core_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    seq_t exp_q;
    seq_t old_q;

    emb_block_core_if bus ();

    emb_block_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic emb_t ref_emb(input logic [7:0] c);
        return {c, ~c, c ^ 8'hA5};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input seq_t obs, input seq_t exv);
        total++;
        assert (obs === exv) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exv);
        total++;
        assert (obs === exv) else begin
            bad++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exv);
        end
    endtask

    task automatic chk_slot(input string tag, input int k, input emb_t exv);
        emb_t obs;
        obs = bus.q[k*EMB_DIM +: EMB_DIM];
        total++;
        assert (obs === exv) else begin
            bad++;
            $error("FAIL %s slot%0d obs=%h exp=%h", tag, k, obs, exv);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        bus.run = 1'b0;
        bus.d   = '0;

        // reset
        #12;
        chk("rst_q", bus.q, '0);
        chk1("rst_valid", bus.valid, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("idle_q", bus.q, '0);
            chk1("idle_valid", bus.valid, 1'b0);
        end

        // fill with d=0
        for (int k = 0; k < N_LEN; k++) exp_q[k*EMB_DIM +: EMB_DIM] = 24'h00FFA5;
        bus.run = 1'b1;
        bus.d   = 8'h00;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (i <= N_LEN) chk_slot("fill0", i - 1, 24'h00FFA5);
            chk1("fill0_valid", bus.valid, i >= N_LEN);
            if (i >= N_LEN) chk("fill0_q", bus.q, exp_q);
        end

        // drop, then refill with d=1
        bus.run = 1'b0;
        step();
        chk1("drop_valid", bus.valid, 1'b0);
        chk("drop_q_kept", bus.q, exp_q);
        bus.d   = 8'h01;
        bus.run = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (i <= N_LEN) chk_slot("fill1_new", i - 1, 24'h01FEA4);
            if (i < N_LEN) chk_slot("fill1_stale", i, 24'h00FFA5);
            chk1("fill1_valid", bus.valid, i >= N_LEN);
        end
        for (int k = 0; k < N_LEN; k++) exp_q[k*EMB_DIM +: EMB_DIM] = 24'h01FEA4;
        chk("fill1_q", bus.q, exp_q);

        // distinct characters 0..15
        bus.run = 1'b0;
        step();
        bus.run = 1'b1;
        for (int i = 0; i < N_LEN; i++) begin
            bus.d = 8'(i);
            step();
        end
        chk1("dist_valid", bus.valid, 1'b1);
        chk_slot("dist_hand", 15, 24'h0FF0AA);
        chk_slot("dist_hand", 2, 24'h02FDA7);
        for (int k = 0; k < N_LEN; k++) exp_q[k*EMB_DIM +: EMB_DIM] = ref_emb(8'(k));
        chk("dist_q", bus.q, exp_q);

        // DONE holds: d ignored
        bus.d = 8'h55;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("done_hold_q", bus.q, exp_q);
            chk1("done_hold_valid", bus.valid, 1'b1);
        end

        // abort after 7 characters, then restart
        bus.run = 1'b0;
        step();
        bus.run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.d = 8'h30 + 8'(i);
            step();
            chk1("abort_fill_valid", bus.valid, 1'b0);
        end
        chk_slot("abort_slot6", 6, ref_emb(8'h36));
        chk_slot("abort_stale7", 7, ref_emb(8'h07));
        bus.run = 1'b0;
        step();
        chk1("abort_valid", bus.valid, 1'b0);
        bus.run = 1'b1;
        for (int i = 1; i <= N_LEN; i++) begin
            bus.d = 8'h40 + 8'(i - 1);
            step();
            chk1("restart_valid", bus.valid, i == N_LEN);
        end
        chk_slot("restart_slot0", 0, 24'h40BFE5);

        // async reset between edges while in DONE
        #2;
        rst_n = 1'b0;
        #1;
        chk1("arst_valid", bus.valid, 1'b0);
        chk("arst_q", bus.q, '0);

        // release mid-stream: first edge writes slot 0
        bus.d = 8'h77;
        #1;
        rst_n = 1'b1;
        step();
        chk_slot("rel_slot0", 0, 24'h7788D2);
        chk_slot("rel_slot1", 1, 24'h000000);
        chk1("rel_valid", bus.valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
